// File: rtl/rsdp_reader_verify_pkg.sv
// Shared constants, FSM state type and GF(127) ones'-complement helpers
// for the RSDP reader-side verifier.
package rsdp_pkg;

    localparam int          N_ELEM       = 34;
    localparam int          ELEM_W       = 7;
    localparam int          KEY_W        = 4;
    localparam logic [6:0]  NEG_ZERO     = 7'h7F;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_ISSUE,
        ST_PROD,
        ST_CHECK,
        ST_DONE
    } state_t;

    // A rotate by 7 returns the operand unchanged, so e=7 behaves as e=0.
    function automatic logic [6:0] rotl7(input logic [6:0] v, input logic [2:0] e);
        logic [13:0] w;
        w = {v, v} << e;
        return w[13:7];
    endfunction

    function automatic logic [6:0] add_mod127(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[6:0] + {6'b0, s[7]};
    endfunction

    function automatic logic [6:0] norm127(input logic [6:0] v);
        return (v == NEG_ZERO) ? 7'h00 : v;
    endfunction

endpackage

// File: rtl/rsdp_reader_verify_if.sv
// Reader/tag bus: challenge vector, load/latch strobes and the tag response.
interface rsdp_reader_verify_if
    import rsdp_pkg::*;
#(
    parameter int N = N_ELEM
);
    logic [N*ELEM_W-1:0] b;
    logic                ldb;
    logic                innerprod;
    logic [ELEM_W-1:0]   u;

    modport master (output b, ldb, innerprod, input u);
    modport slave  (input b, ldb, innerprod, output u);
endinterface

// File: rtl/rsdp_chal_lfsr.sv
// Seeded 16-bit challenge LFSR; advances 7 steps per enabled cycle and
// presents the low 7 bits of the advanced state as the next element.
module rsdp_chal_lfsr
    import rsdp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [15:0]       seed_i,
    input  logic              en_i,
    output logic [ELEM_W-1:0] elem_o
);
    logic [15:0] state_q;
    logic [15:0] state_d;
    logic [15:0] adv;

    always_comb begin
        adv = state_q;
        for (int k = 0; k < ELEM_W; k++) begin
            adv = {^(adv & LFSR_TAPS), adv[15:1]};
        end
    end

    assign elem_o = adv[ELEM_W-1:0];

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 16'h0000) ? LFSR_DEFAULT : seed_i;
        end else if (en_i) begin
            state_d = adv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LFSR_DEFAULT;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/rsdp_reader_verify.sv
// Reader-side RSDP verifier: issues LFSR challenges to the tag, accumulates the
// expected inner product serially and checks the tag response over ROUNDS rounds.
//
//   state    | meaning
//   IDLE     | waiting for start; ldy loads the key register
//   GEN      | N cycles: shift challenge element into b, accumulate expected term
//   ISSUE    | ldb strobe, tag loads b
//   PROD     | innerprod strobe, tag latches u
//   CHECK    | compare u with expected; next round, or verdict
//   DONE     | one-cycle done pulse
module rsdp_reader_verify
    import rsdp_pkg::*;
#(
    parameter int N      = N_ELEM,
    parameter int ROUNDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          seed,
    input  logic [N*KEY_W-1:0]   y,
    input  logic                 ldy,
    rsdp_reader_verify_if.master tag,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);
    localparam int BW = N * ELEM_W;
    localparam int KW = N * KEY_W;
    localparam int CW = $clog2(N + 1);
    localparam int RW = $clog2(ROUNDS + 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     b_q, b_d;
    logic [KW-1:0]     key_q, key_d;
    logic [KW-1:0]     wkey_q, wkey_d;
    logic [ELEM_W-1:0] acc_q, acc_d;
    logic [CW-1:0]     elem_cnt_q, elem_cnt_d;
    logic [RW-1:0]     round_q, round_d;
    logic              pass_q, pass_d;

    logic              lfsr_load;
    logic              lfsr_en;
    logic [ELEM_W-1:0] elem;
    logic [ELEM_W-1:0] term_rot;
    logic [ELEM_W-1:0] term;

    rsdp_chal_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load),
        .seed_i (seed),
        .en_i   (lfsr_en),
        .elem_o (elem)
    );

    assign term_rot = rotl7(elem, wkey_q[2:0]);
    assign term     = wkey_q[3] ? ~term_rot : term_rot;

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        key_d      = key_q;
        wkey_d     = wkey_q;
        acc_d      = acc_q;
        elem_cnt_d = elem_cnt_q;
        round_d    = round_q;
        pass_d     = pass_q;
        lfsr_load  = 1'b0;
        lfsr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ldy) begin
                    key_d = y;
                end
                if (start) begin
                    state_d    = ST_GEN;
                    lfsr_load  = 1'b1;
                    round_d    = '0;
                    pass_d     = 1'b0;
                    acc_d      = '0;
                    elem_cnt_d = CW'(N - 1);
                    wkey_d     = ldy ? y : key_q;
                end
            end
            ST_GEN: begin
                lfsr_en = 1'b1;
                b_d     = {elem, b_q[BW-1:ELEM_W]};
                wkey_d  = wkey_q >> KEY_W;
                acc_d   = add_mod127(acc_q, term);
                if (elem_cnt_q == '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    elem_cnt_d = elem_cnt_q - 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_PROD;
            ST_PROD:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (norm127(tag.u) != norm127(acc_q)) begin
                    pass_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (round_q == RW'(ROUNDS - 1)) begin
                    pass_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    round_d    = round_q + 1'b1;
                    wkey_d     = key_q;
                    acc_d      = '0;
                    elem_cnt_d = CW'(N - 1);
                    state_d    = ST_GEN;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            b_q        <= '0;
            key_q      <= '0;
            wkey_q     <= '0;
            acc_q      <= '0;
            elem_cnt_q <= '0;
            round_q    <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            key_q      <= key_d;
            wkey_q     <= wkey_d;
            acc_q      <= acc_d;
            elem_cnt_q <= elem_cnt_d;
            round_q    <= round_d;
            pass_q     <= pass_d;
        end
    end

    assign tag.b         = b_q;
    assign tag.ldb       = (state_q == ST_ISSUE);
    assign tag.innerprod = (state_q == ST_PROD);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;

endmodule

// File: tb/tb_rsdp_reader_verify.sv
// Scoreboard bench for rsdp_reader_verify: a tag model answers innerprod,
// expected challenges and verdicts are queued at stimulus time and popped by a monitor.
module tb_rsdp_reader_verify;
    import rsdp_pkg::*;

    localparam int N      = 34;
    localparam int ROUNDS = 4;
    localparam int RLEN   = N + 3;
    localparam int BW     = N * ELEM_W;
    localparam int KW     = N * KEY_W;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          ldy   = 1'b0;
    logic [15:0]   seed  = 16'h0000;
    logic [KW-1:0] y     = '0;
    logic          busy, done, pass;

    rsdp_reader_verify_if #(.N(N)) tag();

    rsdp_reader_verify #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .seed  (seed),
        .y     (y),
        .ldy   (ldy),
        .tag   (tag),
        .busy  (busy),
        .done  (done),
        .pass  (pass)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [BW-1:0] b; int cyc; } bexp_t;
    typedef struct { logic p; int cyc; } dexp_t;
    bexp_t bq[$];
    dexp_t dq[$];

    int            n_vec = 0;
    int            n_err = 0;
    int            start_cyc = 0;
    bit            done_seen = 1'b0;
    logic [KW-1:0] tag_key = '0;
    int            bad_round = -1;
    bit            zero_trick = 1'b0;
    int            tag_round = 0;
    int            zero_hits = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] step7(input logic [15:0] s);
        logic [15:0] t;
        logic        fb;
        t = s;
        repeat (7) begin
            fb = t[0] ^ t[2] ^ t[3] ^ t[5];
            t  = {fb, t[15:1]};
        end
        return t;
    endfunction

    // Integer model of the inner product mod 127 (value range 0..126).
    function automatic int exp_of(input logic [BW-1:0] bv, input logic [KW-1:0] key);
        int acc, t, e;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            t = int'(bv[7*i +: 7]);
            e = int'(key[4*i +: 3]);
            if (e == 7) e = 0;
            t = (t << e) % 127;
            if (key[4*i+3]) t = (127 - t) % 127;
            acc = (acc + t) % 127;
        end
        return acc;
    endfunction

    task automatic plan(input logic [15:0] sd, input int bad);
        logic [15:0]   s;
        logic [BW-1:0] bv;
        bexp_t         be;
        dexp_t         de;
        s = (sd == 16'h0000) ? 16'hACE1 : sd;
        for (int r = 0; r < ROUNDS; r++) begin
            for (int i = 0; i < N; i++) begin
                s = step7(s);
                bv[7*i +: 7] = s[6:0];
            end
            be.b = bv;
            be.cyc = r * RLEN + N + 1;
            bq.push_back(be);
            if (r == bad) begin
                de.p = 1'b0;
                de.cyc = (r + 1) * RLEN + 1;
                dq.push_back(de);
                return;
            end
        end
        de.p = 1'b1;
        de.cyc = ROUNDS * RLEN + 1;
        dq.push_back(de);
    endtask

    // Monitor: pops expected challenge on ldb, expected verdict on done.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (tag.ldb) begin
                if (bq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ldb: ldb at cycle %0d, none required", cyc - start_cyc);
                end else begin
                    bexp_t e;
                    e = bq.pop_front();
                    chk("b_vector", tag.b, e.b);
                    chk("ldb_cycle", BW'(cyc - start_cyc), BW'(e.cyc));
                end
            end
            if (done) begin
                done_seen = 1'b1;
                if (dq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: done at cycle %0d, none required", cyc - start_cyc);
                end else begin
                    dexp_t e;
                    e = dq.pop_front();
                    chk("pass", BW'(pass), BW'(e.p));
                    chk("done_cycle", BW'(cyc - start_cyc), BW'(e.cyc));
                end
            end
        end
    end

    // Tag model: answers innerprod with the inner product of the loaded b.
    initial begin
        tag.u = '0;
        forever begin
            @(negedge clk);
            if (!rst && tag.innerprod) begin
                int v;
                v = exp_of(tag.b, tag_key);
                if (tag_round == bad_round) begin
                    tag.u = 7'((v + 1) % 127);
                end else if (zero_trick && v == 0) begin
                    tag.u = NEG_ZERO;
                    zero_hits++;
                end else begin
                    tag.u = 7'(v);
                end
                tag_round++;
            end
        end
    end

    task automatic run(input logic [15:0] sd, input logic [KW-1:0] key, input logic [KW-1:0] tkey,
                       input int bad, input bit zt, input bit disturb);
        int waited;
        @(negedge clk);
        y = key;
        ldy = 1'b1;
        @(negedge clk);
        ldy = 1'b0;
        y = '0;
        tag_key = tkey;
        bad_round = bad;
        zero_trick = zt;
        tag_round = 0;
        done_seen = 1'b0;
        plan(sd, bad);
        seed = sd;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        seed = 16'h5A5A;
        waited = 0;
        while (!done_seen && waited < 400) begin
            @(negedge clk);
            waited++;
            if (disturb) begin
                case (cyc - start_cyc)
                    20: begin ldy = 1'b1; y = ~key; end
                    21: begin ldy = 1'b0; y = '0; end
                    50: begin start = 1'b1; seed = 16'hFFFF; end
                    51: start = 1'b0;
                    default: ;
                endcase
            end
        end
        chk("done_within_budget", BW'(done_seen), BW'(1));
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", BW'(bq.size() + dq.size()), BW'(0));
        bq.delete();
        dq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KW-1:0] k7, k8, kr;
        logic [15:0]   s, zseed;
        logic [BW-1:0] bv;
        bit            found;

        k7 = {N{4'h7}};
        k8 = {N{4'h8}};
        for (int i = 0; i < N; i++) kr[4*i +: 4] = 4'((i * 5 + 3) % 16);

        repeat (3) @(negedge clk);
        chk("reset_b", tag.b, '0);
        chk("reset_ctrl", BW'({tag.ldb, tag.innerprod, busy, done, pass}), '0);
        rst = 1'b0;

        run(16'h0001, '0, '0, -1, 1'b0, 1'b0);
        run(16'h0001, '0, '0, 1, 1'b0, 1'b0);
        run(16'h0001, k7, '0, -1, 1'b0, 1'b0);

        found = 1'b0;
        zseed = 16'h0001;
        for (int sd = 1; sd < 20000 && !found; sd++) begin
            s = 16'(sd);
            for (int i = 0; i < N; i++) begin
                s = step7(s);
                bv[7*i +: 7] = s[6:0];
            end
            if (exp_of(bv, k8) == 0) begin
                zseed = 16'(sd);
                found = 1'b1;
            end
        end
        chk("zero_seed_found", BW'(found), BW'(1));
        zero_hits = 0;
        run(zseed, k8, k8, -1, 1'b1, 1'b0);
        chk("neg_zero_returned", BW'(zero_hits > 0), BW'(1));

        run(16'h0000, kr, kr, -1, 1'b0, 1'b0);
        run(16'hACE1, kr, kr, -1, 1'b0, 1'b0);

        // Abort at GEN cycle 10, then rerun the same seed with ignored pulses.
        @(negedge clk);
        y = kr;
        ldy = 1'b1;
        @(negedge clk);
        ldy = 1'b0;
        done_seen = 1'b0;
        seed = 16'h1234;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - start_cyc < 10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_b", tag.b, '0);
        chk("abort_ctrl", BW'({tag.ldb, tag.innerprod, busy, done, pass}), '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", BW'(done_seen), BW'(0));
        run(16'h1234, kr, kr, -1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rsdp_reader_verify.md
# rsdp_reader_verify

Reader-side verifier for the RSDP challenge–response authentication. It generates pseudo-random challenges and drives them to the tag through the tag's `b`/`ldb`/`innerprod` interface. It computes the expected response serially, one element per cycle, from its own copy of the secret key, then compares it against the tag's `u`. It runs a configurable number of rounds and reports pass/fail.

## Interface
Parameters:
- `N`, 34: number of challenge/key elements.
- `ROUNDS`, 4: rounds per authentication; all must match for a pass.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `start`  in  1: begin authentication; sampled only in IDLE.
- `seed`  in  16: LFSR seed, captured on the accepted `start`.
- `y`  in  4N: secret key; element i at `[4i+3:4i]`; `[4i+2:4i]` = exponent e, `[4i+3]` = sign s.
- `ldy`  in  1: load `y` into the key register; honoured only in IDLE.
- `u`  in  7: tag response.
- `b`  out  7N: challenge; element i at `[7i+6:7i]`.
- `ldb`  out  1: one-cycle strobe; the tag loads `b`.
- `innerprod`  out  1: one-cycle strobe; the tag latches `u`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the verdict is final.
- `pass`  out  1: verdict; valid from `done` until the next accepted `start`.

## Operation
- Arithmetic is over GF(127) as 7-bit ones' complement.
  - Addition: 8-bit sum, end-around carry.
  - Negation: bitwise NOT.
  - Multiplication by 2^e: 7-bit rotate-left by e.
  - e=7 is treated as e=0.
  - `7'h7F` ≡ 0: both the expected value and `u` are normalised to `7'h00` before comparison.
- Term i = rotl7(b_i, e_i), complemented when s_i=1. Expected value = sum of all terms mod 127; the accumulator starts at 0 each round.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - `seed`=0 is replaced by `16'hACE1`.
  - Each element cycle advances the LFSR 7 steps (combinational); the element is the advanced state's `[6:0]`.
  - State persists across rounds.
- FSM:
  - IDLE: `start` → GEN. Capture seed, clear the round counter, clear `pass`.
  - GEN (N cycles): per cycle, shift the new element into `b` at the top and shift `b` right by 7, so element 0 ends at `[6:0]`. Consume the key nibble from a working copy shifted right by 4, and accumulate. After N cycles → ISSUE.
  - ISSUE: `ldb`=1 → PROD.
  - PROD: `innerprod`=1 → CHECK.
  - CHECK: compare `u` with the expected value.
    - Mismatch → DONE with `pass`=0.
    - Match and last round → DONE with `pass`=1.
    - Otherwise increment the round counter, reload the working key copy → GEN.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored; `ldy` outside IDLE is ignored.
- `b` holds its value after ISSUE until the next GEN shift.

## Timing
- Reset value of every output is 0. On reset: FSM to IDLE, LFSR = `16'hACE1`, accumulator and counters 0, key register 0.
- Reset mid-operation aborts immediately; no `done` is produced.
- Round length is N+3 cycles: GEN N, ISSUE 1, PROD 1, CHECK 1.
- With `start` accepted at edge 0:
  - First `ldb` is high in cycle N+1; `innerprod` is high in cycle N+2.
  - `u` is sampled in cycle N+3.
  - `done` is high in cycle ROUNDS·(N+3)+1 on a full pass, or earlier on the first mismatch.
- The tag contract is that `u` is valid the cycle after `innerprod`.

## Structure
- `rsdp_pkg` holds:
  - constants `N_ELEM`=34, `ELEM_W`=7, `KEY_W`=4, `NEG_ZERO`=`7'h7F`, `LFSR_DEFAULT`=`16'hACE1`, and the tap mask;
  - the FSM state typedef;
  - functions `rotl7`, `add_mod127`, `norm127`.
- Sub-module `rsdp_chal_lfsr` contains the seeded 16-bit LFSR with the 7-step advance and the element output, enabled by GEN.

## Test plan
- Key all zero (every term = b_i), `seed`=`16'h0001`, ROUNDS=4, golden tag model → 4 ISSUE/PROD pairs spaced 37 cycles apart; `done` at cycle 149; `pass`=1.
- Same setup, tag returns expected+1 in round 2 → `done` at cycle 75; `pass`=0; no third `ldb`.
- Key with all e=7, s=0 versus all e=0, s=0, same seed → identical expected values; `pass`=1 against the same tag model.
- Tag model returns `7'h7F` whenever the golden value is `7'h00` (key all s=1, e=0; search for a seed that yields sum ≡ 0) → `pass`=1.
- `seed`=0 versus `seed`=`16'hACE1` → bit-identical `b` sequences across all rounds.
- Assert `rst` at GEN cycle 10 → all outputs 0 within the same cycle. Then `start` with the same seed → `b` matches the unreset run; `start`/`ldy` pulses during `busy` have no effect.
